lexer_ctrl: RTL

Sequencer for the lexer pipeline. On START it clears the lexer, streams source bytes from a synchronous-read source RAM into the lexer at one byte per cycle, and writes every emitted 16-bit token into a token RAM. It always terminates the stream with an EOF byte, drains the lexer pipeline, then reports DONE together with the token count. It sits between the host-loaded source buffer and the parser's token buffer.

---
 rtl/lexer_pkg.sv | 21 ++
 rtl/lexer_tok_writer.sv | 73 +++++++
 rtl/lexer_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lexer_pkg.sv
// Shared state encoding, terminator bytes and token width for the lexer sequencer.
package lexer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_TAIL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] EOF_NUL = 8'h00;
    localparam logic [7:0] EOF_FF  = 8'hFF;
    localparam int         TOK_W   = 16;

    function automatic logic is_eof(input logic [7:0] b);
        return (b == EOF_NUL) || (b == EOF_FF);
    endfunction

endpackage

// File: rtl/lexer_tok_writer.sv
// Token capture stage: registers each lexer token into a token RAM write,
// counts tokens and flags overflow once the RAM is full.
module lexer_tok_writer
    import lexer_pkg::*;
#(
    parameter int TOK_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cap_en,
    input  logic              tok_vld,
    input  logic [TOK_W-1:0]  tok_data,
    output logic              tok_we,
    output logic [TOK_AW-1:0] tok_addr,
    output logic [TOK_W-1:0]  tok_wdata,
    output logic [TOK_AW:0]   tok_cnt,
    output logic              overflow
);

    localparam logic [TOK_AW:0] CAPACITY = {1'b1, {TOK_AW{1'b0}}};

    logic              we_q, we_d;
    logic [TOK_AW-1:0] addr_q, addr_d;
    logic [TOK_W-1:0]  wdata_q, wdata_d;
    logic [TOK_AW:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (cap_en && tok_vld) begin
            // The count advances with the write so back-to-back tokens get consecutive slots.
            if (cnt_q == CAPACITY) begin
                ovf_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = cnt_q[TOK_AW-1:0];
                wdata_d = tok_data;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tok_we    = we_q;
    assign tok_addr  = addr_q;
    assign tok_wdata = wdata_q;
    assign tok_cnt   = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/lexer_ctrl.sv
// Lexer sequencer: clears the lexer, streams source bytes, appends EOF, drains, reports DONE.
// Define LEXER_CTRL_CYCLE_CNT_EN to add the CYCLE_CNT busy-cycle counter output.
module lexer_ctrl
    import lexer_pkg::*;
#(
    parameter int SRC_AW       = 12,
    parameter int TOK_AW       = 10,
    parameter int CLEAR_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [SRC_AW:0]   SRC_LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERFLOW,
    output logic [TOK_AW:0]   TOK_CNT,
    output logic [SRC_AW-1:0] SRC_ADDR,
    input  logic [7:0]        SRC_DATA,
    output logic              LEX_RST,
    output logic              LEX_I_VALID,
    output logic [7:0]        LEX_I_DATA,
    input  logic              LEX_O_VALID,
    input  logic [TOK_W-1:0]  LEX_O_DATA,
    input  logic              LEX_FOUND_EOF,
    output logic              TOK_WE,
    output logic [TOK_AW-1:0] TOK_ADDR,
    output logic [TOK_W-1:0]  TOK_WDATA
`ifdef LEXER_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]       CYCLE_CNT
`endif
);

    localparam int CNT_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SRC_AW:0]   addr_q, addr_d;
    logic [SRC_AW:0]   len_q, len_d;
    logic              rd_vld_q, rd_vld_d;
    logic              start_ok;
    logic              cap_en;

    assign start_ok = (state_q == ST_IDLE) && START;
    assign cap_en   = (state_q == ST_FEED) || (state_q == ST_TAIL) || (state_q == ST_DRAIN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        rd_vld_d    = 1'b0;
        LEX_RST     = 1'b0;
        LEX_I_VALID = 1'b0;
        LEX_I_DATA  = '0;
        unique case (state_q)
            ST_IDLE: begin
                LEX_RST = 1'b1;
                if (START) begin
                    state_d = ST_CLEAR;
                    len_d   = SRC_LEN;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_CLEAR: begin
                LEX_RST = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? ST_TAIL : ST_FEED;
                end
            end
            ST_FEED: begin
                LEX_I_VALID = rd_vld_q;
                LEX_I_DATA  = rd_vld_q ? SRC_DATA : 8'h00;
                // A terminator is fed itself but cancels the read still in flight.
                if (rd_vld_q && is_eof(SRC_DATA)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else if (addr_q == len_q) begin
                    state_d = ST_TAIL;
                end else begin
                    rd_vld_d = 1'b1;
                    addr_d   = addr_q + 1'b1;
                end
            end
            ST_TAIL: begin
                LEX_I_VALID = 1'b1;
                LEX_I_DATA  = EOF_NUL;
                state_d     = ST_DRAIN;
                cnt_d       = '0;
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (LEX_FOUND_EOF || (cnt_q == DRN_LAST)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = (state_q == ST_DONE);
    assign SRC_ADDR = addr_q[SRC_AW-1:0];

    lexer_tok_writer #(
        .TOK_AW(TOK_AW)
    ) u_tok_writer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr      (start_ok || (state_q == ST_CLEAR)),
        .cap_en   (cap_en),
        .tok_vld  (LEX_O_VALID),
        .tok_data (LEX_O_DATA),
        .tok_we   (TOK_WE),
        .tok_addr (TOK_ADDR),
        .tok_wdata(TOK_WDATA),
        .tok_cnt  (TOK_CNT),
        .overflow (OVERFLOW)
    );

`ifdef LEXER_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start_ok) begin
            cyc_d = '0;
        end else if (BUSY && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign CYCLE_CNT = cyc_q;
`endif

endmodule
